// File: rtl/fish_draw_scheduler_if.sv
// Bundle between the PIO command words, the LBM stepper and the shared
// obstacle-drawing engine. The scheduler sits on the slave side.
interface fish_draw_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 3
);
  logic [NUM_REQ*32-1:0] req_word;
  logic                  lbm_busy;
  logic                  eng_done;
  logic                  ovf_clear;
  logic                  step_pause;
  logic                  eng_start;
  logic [8:0]            eng_x;
  logic [8:0]            eng_y;
  logic [1:0]            eng_shape;
  logic                  eng_erase;
  logic [PTR_W-1:0]      grant_id;
  logic [NUM_REQ-1:0]    pending;
  logic [NUM_REQ-1:0]    overrun;
  logic                  sched_busy;

  modport master (
    output req_word, lbm_busy, eng_done, ovf_clear,
    input  step_pause, eng_start, eng_x, eng_y, eng_shape, eng_erase,
           grant_id, pending, overrun, sched_busy
  );

  modport slave (
    input  req_word, lbm_busy, eng_done, ovf_clear,
    output step_pause, eng_start, eng_x, eng_y, eng_shape, eng_erase,
           grant_id, pending, overrun, sched_busy
  );
endinterface

// File: rtl/fish_draw_scheduler.sv
// Round-robin scheduler sharing one obstacle-drawing engine between NUM_REQ
// toggle-signalled PIO command words; pauses the LBM stepper around each draw.
module fish_draw_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  fish_draw_scheduler_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_PAUSE, S_LAUNCH, S_DRAW, S_RELEASE
  } state_t;

  typedef struct packed {
    logic       erase;
    logic [1:0] shape;
    logic [8:0] y;
    logic [8:0] x;
  } cmd_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   prev_go_q, prev_go_d;
  logic [NUM_REQ-1:0]   pending_q, pending_d;
  logic [NUM_REQ-1:0]   overrun_q, overrun_d;
  cmd_t [NUM_REQ-1:0]   cmd_q, cmd_d;
  cmd_t                 eng_q, eng_d;
  logic [PTR_W-1:0]     grant_q, grant_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0]   tog, clr, ovr_set;
  logic [PTR_W-1:0]     pick_hi, pick_lo, pick;
  logic                 hit_hi;
  logic                 unused_rsvd;

  always_comb begin
    prev_go_d   = '0;
    tog         = '0;
    clr         = '0;
    ovr_set     = '0;
    cmd_d       = cmd_q;
    unused_rsvd = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      prev_go_d[i] = bus.req_word[32*i+31];
      tog[i]       = prev_go_d[i] ^ prev_go_q[i];
      unused_rsvd  = unused_rsvd ^ (^bus.req_word[32*i+18 +: 10]);
      if (tog[i])
        cmd_d[i] = {bus.req_word[32*i+30 -: 3], bus.req_word[32*i+9 +: 9],
                    bus.req_word[32*i +: 9]};
      if (state_q == S_LAUNCH && grant_q == PTR_W'(i))
        clr[i] = 1'b1;
      // A capture that coincides with the launch clear is a fresh request, not an overwrite.
      ovr_set[i] = tog[i] & pending_q[i] & ~clr[i];
    end
    pending_d = tog | (pending_q & ~clr);
    overrun_d = (bus.ovf_clear ? '0 : overrun_q) | ovr_set;

    // Lowest pending index at or above rr_ptr, else lowest overall (wrap).
    hit_hi  = 1'b0;
    pick_hi = '0;
    pick_lo = '0;
    for (int j = NUM_REQ-1; j >= 0; j--) begin
      if (pending_q[j])
        pick_lo = PTR_W'(j);
      if (pending_q[j] && PTR_W'(j) >= rr_ptr_q) begin
        hit_hi  = 1'b1;
        pick_hi = PTR_W'(j);
      end
    end
    pick = hit_hi ? pick_hi : pick_lo;

    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    eng_d    = eng_q;
    case (state_q)
      S_IDLE:
        if (|pending_q) begin
          grant_d = pick;
          state_d = S_PAUSE;
        end
      S_PAUSE:
        if (!bus.lbm_busy) state_d = S_LAUNCH;
      S_LAUNCH: begin
        for (int i = 0; i < NUM_REQ; i++)
          if (clr[i]) eng_d = cmd_q[i];
        rr_ptr_d = (grant_q == PTR_W'(NUM_REQ-1)) ? '0 : grant_q + 1'b1;
        state_d  = S_DRAW;
      end
      S_DRAW:
        if (bus.eng_done) state_d = S_RELEASE;
      S_RELEASE:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      prev_go_q <= '0;
      pending_q <= '0;
      overrun_q <= '0;
      cmd_q     <= '0;
      eng_q     <= '0;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      prev_go_q <= prev_go_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      cmd_q     <= cmd_d;
      eng_q     <= eng_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign bus.step_pause = (state_q == S_PAUSE) || (state_q == S_LAUNCH) ||
                          (state_q == S_DRAW);
  assign bus.eng_start  = (state_q == S_LAUNCH);
  assign bus.sched_busy = (state_q != S_IDLE);
  assign bus.eng_x      = eng_q.x;
  assign bus.eng_y      = eng_q.y;
  assign bus.eng_shape  = eng_q.shape;
  assign bus.eng_erase  = eng_q.erase;
  assign bus.grant_id   = grant_q;
  assign bus.pending    = pending_q;
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_fish_draw_scheduler.sv
// Directed bench for fish_draw_scheduler: per-cycle vector table plus
// hand sequences for bus-wait, launch collision and reset mid-draw.
module tb_fish_draw_scheduler;
  localparam int NUM_REQ = 2;
  localparam int PTR_W   = 3;
  localparam int NV      = 37;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fish_draw_scheduler_if #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) bus ();
  fish_draw_scheduler #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    logic [31:0] w0, w1;
    logic        b, d, c;
    logic        sp, st, bz;
    logic [1:0]  p, o;
    logic [8:0]  x, y;
    logic        er;
    logic [1:0]  sh;
    logic [2:0]  g;
  } vec_t;

  vec_t tbl[NV];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input logic [31:0] w0, w1, input logic b, d, c,
                              input logic sp, st, bz, input logic [1:0] p, o,
                              input logic [8:0] x, y, input logic er,
                              input logic [1:0] sh, input logic [2:0] g);
    vec_t v;
    v.w0 = w0; v.w1 = w1; v.b = b; v.d = d; v.c = c;
    v.sp = sp; v.st = st; v.bz = bz; v.p = p; v.o = o;
    v.x = x; v.y = y; v.er = er; v.sh = sh; v.g = g;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_start(input int max_cyc, input string name);
    int n;
    n = 0;
    while (bus.eng_start !== 1'b1 && n < max_cyc) begin
      cyc();
      n++;
    end
    chk(name, {31'b0, bus.eng_start}, 32'd1);
  endtask

  initial begin
    bus.req_word = '0; bus.lbm_busy = 1'b0; bus.eng_done = 1'b0; bus.ovf_clear = 1'b0;

    //         w0            w1            b d c  sp st bz  p  o   x   y er sh g
    tbl[0]  = mk(32'h0,        32'h0,        0,0,0, 0,0,0, 0,0,   0,  0,0,0,0);
    tbl[1]  = mk(32'h8000_3219,32'h0,        0,0,0, 0,0,0, 1,0,   0,  0,0,0,0);
    tbl[2]  = mk(32'h8000_3219,32'h0,        0,0,0, 1,0,1, 1,0,   0,  0,0,0,0);
    tbl[3]  = mk(32'h8000_3219,32'h0,        0,0,0, 1,1,1, 1,0,   0,  0,0,0,0);
    tbl[4]  = mk(32'h8000_3219,32'h0,        0,0,0, 1,0,1, 0,0,  25, 25,0,0,0);
    tbl[5]  = mk(32'h8000_3219,32'h0,        0,1,0, 0,0,1, 0,0,  25, 25,0,0,0);
    tbl[6]  = mk(32'h8000_3219,32'h0,        0,0,0, 0,0,0, 0,0,  25, 25,0,0,0);
    tbl[7]  = mk(32'h8000_3219,32'h8000_0005,1,0,0, 0,0,0, 2,0,  25, 25,0,0,0);
    tbl[8]  = mk(32'h8000_3219,32'h0000_0009,1,0,0, 1,0,1, 2,2,  25, 25,0,0,1);
    tbl[9]  = mk(32'h8000_3219,32'h0000_0009,1,0,0, 1,0,1, 2,2,  25, 25,0,0,1);
    tbl[10] = mk(32'h8000_3219,32'h0000_0009,0,0,0, 1,1,1, 2,2,  25, 25,0,0,1);
    tbl[11] = mk(32'h8000_3219,32'h0000_0009,0,0,0, 1,0,1, 0,2,   9,  0,0,0,1);
    tbl[12] = mk(32'h8000_3219,32'h0000_0009,0,0,1, 1,0,1, 0,0,   9,  0,0,0,1);
    tbl[13] = mk(32'h8000_3219,32'h0000_0009,0,1,0, 0,0,1, 0,0,   9,  0,0,0,1);
    tbl[14] = mk(32'h8000_3219,32'h0000_0009,0,0,0, 0,0,0, 0,0,   9,  0,0,0,1);
    tbl[15] = mk(32'h4000_0064,32'h9000_0007,0,0,0, 0,0,0, 3,0,   9,  0,0,0,1);
    tbl[16] = mk(32'h4000_0064,32'h9000_0007,0,0,0, 1,0,1, 3,0,   9,  0,0,0,0);
    tbl[17] = mk(32'h4000_0064,32'h9000_0007,0,0,0, 1,1,1, 3,0,   9,  0,0,0,0);
    tbl[18] = mk(32'h4000_0064,32'h9000_0007,0,0,0, 1,0,1, 2,0, 100,  0,1,0,0);
    tbl[19] = mk(32'h4000_0064,32'h9000_0007,0,1,0, 0,0,1, 2,0, 100,  0,1,0,0);
    tbl[20] = mk(32'h4000_0064,32'h9000_0007,0,0,0, 0,0,0, 2,0, 100,  0,1,0,0);
    tbl[21] = mk(32'h4000_0064,32'h9000_0007,0,0,0, 1,0,1, 2,0, 100,  0,1,0,1);
    tbl[22] = mk(32'h4000_0064,32'h9000_0007,0,0,0, 1,1,1, 2,0, 100,  0,1,0,1);
    tbl[23] = mk(32'h4000_0064,32'h9000_0007,0,0,0, 1,0,1, 0,0,   7,  0,0,1,1);
    tbl[24] = mk(32'h4000_0064,32'h9000_0007,0,1,0, 0,0,1, 0,0,   7,  0,0,1,1);
    tbl[25] = mk(32'h4000_0064,32'h9000_0007,0,0,0, 0,0,0, 0,0,   7,  0,0,1,1);
    tbl[26] = mk(32'h8000_0011,32'h0000_0422,0,0,0, 0,0,0, 3,0,   7,  0,0,1,1);
    tbl[27] = mk(32'h8000_0011,32'h0000_0422,0,0,0, 1,0,1, 3,0,   7,  0,0,1,0);
    tbl[28] = mk(32'h8000_0011,32'h0000_0422,0,0,0, 1,1,1, 3,0,   7,  0,0,1,0);
    tbl[29] = mk(32'h8000_0011,32'h0000_0422,0,0,0, 1,0,1, 2,0,  17,  0,0,0,0);
    tbl[30] = mk(32'h8000_0011,32'h0000_0422,0,1,0, 0,0,1, 2,0,  17,  0,0,0,0);
    tbl[31] = mk(32'h8000_0011,32'h0000_0422,0,0,0, 0,0,0, 2,0,  17,  0,0,0,0);
    tbl[32] = mk(32'h8000_0011,32'h0000_0422,0,0,0, 1,0,1, 2,0,  17,  0,0,0,1);
    tbl[33] = mk(32'h8000_0011,32'h0000_0422,0,0,0, 1,1,1, 2,0,  17,  0,0,0,1);
    tbl[34] = mk(32'h8000_0011,32'h0000_0422,0,1,0, 1,0,1, 0,0,  34,  2,0,0,1);
    tbl[35] = mk(32'h8000_0011,32'h0000_0422,0,1,0, 0,0,1, 0,0,  34,  2,0,0,1);
    tbl[36] = mk(32'h8000_0011,32'h0000_0422,0,0,0, 0,0,0, 0,0,  34,  2,0,0,1);

    #1;
    chk("rst step_pause", {31'b0, bus.step_pause}, 0);
    chk("rst eng_start",  {31'b0, bus.eng_start},  0);
    chk("rst sched_busy", {31'b0, bus.sched_busy}, 0);
    chk("rst pending",    {30'b0, bus.pending},    0);
    chk("rst overrun",    {30'b0, bus.overrun},    0);
    chk("rst eng_x",      {23'b0, bus.eng_x},      0);
    chk("rst grant_id",   {29'b0, bus.grant_id},   0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int k = 0; k < NV; k++) begin
      bus.req_word  = {tbl[k].w1, tbl[k].w0};
      bus.lbm_busy  = tbl[k].b;
      bus.eng_done  = tbl[k].d;
      bus.ovf_clear = tbl[k].c;
      cyc();
      chk($sformatf("v%0d step_pause", k), {31'b0, bus.step_pause}, {31'b0, tbl[k].sp});
      chk($sformatf("v%0d eng_start", k),  {31'b0, bus.eng_start},  {31'b0, tbl[k].st});
      chk($sformatf("v%0d sched_busy", k), {31'b0, bus.sched_busy}, {31'b0, tbl[k].bz});
      chk($sformatf("v%0d pending", k),    {30'b0, bus.pending},    {30'b0, tbl[k].p});
      chk($sformatf("v%0d overrun", k),    {30'b0, bus.overrun},    {30'b0, tbl[k].o});
      chk($sformatf("v%0d eng_x", k),      {23'b0, bus.eng_x},      {23'b0, tbl[k].x});
      chk($sformatf("v%0d eng_y", k),      {23'b0, bus.eng_y},      {23'b0, tbl[k].y});
      chk($sformatf("v%0d eng_erase", k),  {31'b0, bus.eng_erase},  {31'b0, tbl[k].er});
      chk($sformatf("v%0d eng_shape", k),  {30'b0, bus.eng_shape},  {30'b0, tbl[k].sh});
      chk($sformatf("v%0d grant_id", k),   {29'b0, bus.grant_id},   {29'b0, tbl[k].g});
    end
    bus.eng_done = 1'b0; bus.ovf_clear = 1'b0;

    // Boundary wait: stepper busy for 20 cycles after the request.
    bus.lbm_busy = 1'b1;
    bus.req_word = {32'h0000_0422, 32'h0000_3219};
    cyc();
    chk("bw pending", {30'b0, bus.pending}, 1);
    cyc();
    chk("bw pause", {31'b0, bus.step_pause}, 1);
    for (int n = 0; n < 20; n++) begin
      cyc();
      chk($sformatf("bw hold%0d start", n), {31'b0, bus.eng_start}, 0);
      chk($sformatf("bw hold%0d pause", n), {31'b0, bus.step_pause}, 1);
    end
    bus.lbm_busy = 1'b0;
    cyc();
    chk("bw launch", {31'b0, bus.eng_start}, 1);
    cyc();
    chk("bw start_drop", {31'b0, bus.eng_start}, 0);
    chk("bw eng_x", {23'b0, bus.eng_x}, 25);
    chk("bw eng_y", {23'b0, bus.eng_y}, 25);
    for (int n = 0; n < 9; n++) cyc();
    chk("bw draw_pause", {31'b0, bus.step_pause}, 1);
    bus.eng_done = 1'b1;
    cyc();
    bus.eng_done = 1'b0;
    chk("bw release_pause", {31'b0, bus.step_pause}, 0);
    cyc();
    chk("bw idle_busy", {31'b0, bus.sched_busy}, 0);
    chk("bw idle_pending", {30'b0, bus.pending}, 0);

    // Collision: requester 0 toggles again during its own LAUNCH cycle.
    bus.req_word = {32'h0000_0422, 32'h8000_0030};
    cyc(); cyc(); cyc();
    chk("col launch", {31'b0, bus.eng_start}, 1);
    bus.req_word = {32'h0000_0422, 32'h0000_0041};
    cyc();
    chk("col pending", {30'b0, bus.pending}, 1);
    chk("col overrun", {30'b0, bus.overrun}, 0);
    chk("col eng_x_old", {23'b0, bus.eng_x}, 48);
    bus.eng_done = 1'b1;
    cyc();
    bus.eng_done = 1'b0;
    cyc();
    chk("col idle_busy", {31'b0, bus.sched_busy}, 0);
    wait_start(10, "col second_start");
    cyc();
    chk("col eng_x_new", {23'b0, bus.eng_x}, 65);
    chk("col pending_clr", {30'b0, bus.pending}, 0);

    // Reset mid-draw with requester 1 pending.
    bus.req_word = {32'h8000_0001, 32'h0000_0041};
    cyc();
    chk("rd pending_pre", {30'b0, bus.pending}, 2);
    chk("rd in_draw", {31'b0, bus.step_pause}, 1);
    reset_n = 1'b0;
    bus.req_word = '0;
    #1;
    chk("rd step_pause", {31'b0, bus.step_pause}, 0);
    chk("rd eng_start",  {31'b0, bus.eng_start},  0);
    chk("rd pending",    {30'b0, bus.pending},    0);
    chk("rd sched_busy", {31'b0, bus.sched_busy}, 0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    cyc();
    chk("rd post_pending", {30'b0, bus.pending}, 0);
    bus.req_word = {32'h0, 32'h8000_0123};
    wait_start(10, "rd new_start");
    chk("rd grant", {29'b0, bus.grant_id}, 0);
    cyc();
    chk("rd eng_x", {23'b0, bus.eng_x}, 291);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
